// File: rtl/vga_timing_generator.sv
// Purpose: divides clk down to a pixel strobe, scans the raster, emits syncs and blanked colour.
// Latency: hSync/vSync/rgb_out lag hCount/vCount by one pixel period; pix_en/bright/frame_tick are combinational.
// Backpressure: none; the raster free-runs and rgb_in must be valid whenever pix_en is high.
module vga_timing_generator #(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 144,
  parameter int H_DISP_END   = 783,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC       = 2,
  parameter int V_DISP_START = 35,
  parameter int V_DISP_END   = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hSync,
  output logic        vSync,
  output logic [11:0] rgb_out
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYN    = 10'(H_SYNC);
  localparam logic [9:0]       V_SYN    = 10'(V_SYNC);
  localparam logic [9:0]       H_DS     = 10'(H_DISP_START);
  localparam logic [9:0]       H_DE     = 10'(H_DISP_END);
  localparam logic [9:0]       V_DS     = 10'(V_DISP_START);
  localparam logic [9:0]       V_DE     = 10'(V_DISP_END);

  logic [DIV_W-1:0] div_cnt;
  logic             h_last;
  logic             v_last;
  logic             hs_c;
  logic             vs_c;

  // Pixel strobe is the last phase of the divider; reset forces phase 0 so it stays low.
  assign pix_en     = (div_cnt == DIV_LAST);
  assign h_last     = (hCount == H_LAST);
  assign v_last     = (vCount == V_LAST);
  assign frame_tick = pix_en && h_last && v_last;

  // Display window and sync terms decoded from the current (pre-increment) position.
  assign bright = (hCount >= H_DS) && (hCount <= H_DE) &&
                  (vCount >= V_DS) && (vCount <= V_DE);
  assign hs_c   = (hCount >= H_SYN);
  assign vs_c   = (vCount >= V_SYN);

  // Master-clock divider producing one pix_en per CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster position: pixel counter every pix_en, line counter only on the pixel wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hCount <= '0;
        vCount <= v_last ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  // Output stage: syncs and blanked colour registered once per pixel from the current position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hSync   <= 1'b1;
      vSync   <= 1'b1;
      rgb_out <= 12'h000;
    end else if (pix_en) begin
      hSync   <= hs_c;
      vSync   <= vs_c;
      rgb_out <= bright ? rgb_in : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
`timescale 1ns/1ps
module tb_vga_timing_generator;

  // Scaled raster for whole-frame checks; the default instance covers the first line at full size.
  localparam int S_DIV   = 4;
  localparam int S_HT    = 40;
  localparam int S_HS    = 6;
  localparam int S_HDS   = 10;
  localparam int S_HDE   = 33;
  localparam int S_VT    = 12;
  localparam int S_VS    = 2;
  localparam int S_VDS   = 3;
  localparam int S_VDE   = 9;
  localparam int S_FRAME = S_HT * S_VT * S_DIV;   // 1920 clks

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s;
  logic [11:0] rgb_d, rgb_s;
  logic [9:0]  d_h, d_v, s_h, s_v;
  logic        d_bright, d_pix, d_ft, d_hs, d_vs;
  logic        s_bright, s_pix, s_ft, s_hs, s_vs;
  logic [11:0] d_rgb, s_rgb;

  vga_timing_generator u_dut_d (
    .clk(clk), .rst(rst_d), .rgb_in(rgb_d),
    .hCount(d_h), .vCount(d_v), .bright(d_bright), .pix_en(d_pix),
    .frame_tick(d_ft), .hSync(d_hs), .vSync(d_vs), .rgb_out(d_rgb)
  );

  vga_timing_generator #(
    .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_DISP_START(S_HDS), .H_DISP_END(S_HDE),
    .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_DISP_START(S_VDS), .V_DISP_END(S_VDE)
  ) u_dut_s (
    .clk(clk), .rst(rst_s), .rgb_in(rgb_s),
    .hCount(s_h), .vCount(s_v), .bright(s_bright), .pix_en(s_pix),
    .frame_tick(s_ft), .hSync(s_hs), .vSync(s_vs), .rgb_out(s_rgb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic bit s_disp(input int h, input int v);
    return (h >= S_HDS) && (h <= S_HDE) && (v >= S_VDS) && (v <= S_VDE);
  endfunction

  int hs_low, vs_low, nz, nt, found;
  int eh, ev, ph, pv;
  int e_pix, e_cnt, e_hs, e_vs, e_rgb, e_br, e_ft, e_tog;
  int tick_k [2];
  logic [11:0] exp_rgb;
  bit exp_pix;

  initial begin
    rst_d = 1'b0; rst_s = 1'b0; rgb_d = 12'hF00; rgb_s = 12'hF00;
    tick_k[0] = 0; tick_k[1] = 0;

    // ---------------- default instance: reset state ----------------
    repeat (3) @(negedge clk);
    chk("d_rst_hcount", 32'(d_h), 0);
    chk("d_rst_vcount", 32'(d_v), 0);
    chk("d_rst_hsync",  32'(d_hs), 1);
    chk("d_rst_vsync",  32'(d_vs), 1);
    chk("d_rst_rgb",    32'(d_rgb), 0);
    chk("d_rst_pix_en", 32'(d_pix), 0);
    chk("d_rst_ftick",  32'(d_ft), 0);
    chk("d_rst_bright", 32'(d_bright), 0);

    // ---------------- default instance: cadence, first line, hSync width ----------------
    rst_d = 1'b1;
    hs_low = 0; nz = 0; found = 0;
    for (int k = 1; k <= 3300 && found == 0; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        chk("d_pix_cadence", 32'(d_pix), 32'(k % 4 == 3));
        chk("d_h_step",      32'(d_h), 32'(k / 4));
        chk("d_hsync_first", 32'(d_hs), 32'(k < 4));
      end
      if (d_pix) begin
        if (!d_hs) hs_low++;
        if (d_rgb != 12'h000) nz++;
        if (d_h == 10'd799) found = 1;
      end
    end
    chk("d_reach_799", 32'(found), 1);
    chk("d_hsync_low_pixels", 32'(hs_low), 96);
    chk("d_line0_dark", 32'(nz), 0);
    chk("d_v_before_wrap", 32'(d_v), 0);
    chk("d_ftick_line_end", 32'(d_ft), 0);
    @(negedge clk);
    chk("d_wrap_h", 32'(d_h), 0);
    chk("d_wrap_v", 32'(d_v), 1);
    chk("d_wrap_hsync", 32'(d_hs), 1);
    repeat (4) @(negedge clk);
    chk("d_line1_hsync_low", 32'(d_hs), 0);
    chk("d_line1_h", 32'(d_h), 1);

    // ---------------- scaled instance: two full frames with constant F00 ----------------
    rst_s = 1'b1;
    eh = 0; ev = 0; ph = S_HT - 1; pv = S_VT - 1;
    e_pix = 0; e_cnt = 0; e_hs = 0; e_vs = 0; e_rgb = 0; e_br = 0; e_ft = 0;
    nz = 0; vs_low = 0; nt = 0;
    for (int k = 1; k <= 2 * S_FRAME + 8; k++) begin
      @(negedge clk);
      exp_pix = (k % S_DIV == S_DIV - 1);
      if (s_pix !== exp_pix) e_pix++;
      if (int'(s_h) != eh || int'(s_v) != ev) e_cnt++;
      if (s_hs !== (ph >= S_HS)) e_hs++;
      if (s_vs !== (pv >= S_VS)) e_vs++;
      if (s_rgb !== (s_disp(ph, pv) ? 12'hF00 : 12'h000)) e_rgb++;
      if (s_bright !== s_disp(eh, ev)) e_br++;
      if (s_ft !== (exp_pix && eh == S_HT - 1 && ev == S_VT - 1)) e_ft++;
      if (s_pix) begin
        if (s_rgb != 12'h000) nz++;
        if (!s_vs) vs_low++;
      end
      if (s_ft) begin
        if (nt < 2) begin
          tick_k[nt] = k;
          chk("s_frame_lit_pixels", 32'(nz), 32'((S_HDE - S_HDS + 1) * (S_VDE - S_VDS + 1)));
          chk("s_vsync_low_pixels", 32'(vs_low), 32'(S_VS * S_HT));
        end
        nt++;
        nz = 0; vs_low = 0;
      end
      if (exp_pix) begin
        ph = eh; pv = ev;
        if (eh == S_HT - 1) begin
          eh = 0;
          ev = (ev == S_VT - 1) ? 0 : ev + 1;
        end else begin
          eh = eh + 1;
        end
      end
    end
    chk("s_pix_cadence", 32'(e_pix), 0);
    chk("s_counters", 32'(e_cnt), 0);
    chk("s_hsync_track", 32'(e_hs), 0);
    chk("s_vsync_track", 32'(e_vs), 0);
    chk("s_rgb_blanking", 32'(e_rgb), 0);
    chk("s_bright", 32'(e_br), 0);
    chk("s_ftick_shape", 32'(e_ft), 0);
    chk("s_ftick_count", 32'(nt), 2);
    chk("s_ftick_first", 32'(tick_k[0]), 32'(S_FRAME - 1));
    chk("s_ftick_period", 32'(tick_k[1] - tick_k[0]), 32'(S_FRAME));

    // ---------------- scaled instance: rgb_in toggling every clk ----------------
    rst_s = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b1;
    eh = 0; ev = 0; exp_rgb = 12'h000; e_tog = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (s_rgb !== exp_rgb) e_tog++;
      rgb_s = 12'(k * 181 + 7);
      if (k % S_DIV == S_DIV - 1) begin
        exp_rgb = s_disp(eh, ev) ? rgb_s : 12'h000;
        if (eh == S_HT - 1) begin
          eh = 0;
          ev = (ev == S_VT - 1) ? 0 : ev + 1;
        end else begin
          eh = eh + 1;
        end
      end
    end
    chk("s_rgb_sampled_on_pix_en", 32'(e_tog), 0);

    // ---------------- scaled instance: reset mid-frame, colliding with pix_en ----------------
    found = 0;
    for (int k = 0; k < 2 * S_FRAME && found == 0; k++) begin
      @(negedge clk);
      if (s_pix && s_h == 10'd20 && s_v == 10'd5) found = 1;
    end
    chk("s_reach_mid_frame", 32'(found), 1);
    rgb_s = 12'h0F0;
    rst_s = 1'b0;
    @(negedge clk);
    chk("s_abort_h", 32'(s_h), 0);
    chk("s_abort_v", 32'(s_v), 0);
    chk("s_abort_rgb", 32'(s_rgb), 0);
    chk("s_abort_hsync", 32'(s_hs), 1);
    chk("s_abort_vsync", 32'(s_vs), 1);
    chk("s_abort_pix_en", 32'(s_pix), 0);
    chk("s_abort_ftick", 32'(s_ft), 0);
    rst_s = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("s_restart_pix_en", 32'(s_pix), 32'(k == 3));
      chk("s_restart_h", 32'(s_h), 32'(k / 4));
    end
    chk("s_restart_rgb", 32'(s_rgb), 0);
    chk("s_restart_hsync", 32'(s_hs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameter CLK_DIV, default 4: master clocks per pixel (100 MHz to 25 MHz); legal range is 2 or greater.
REQ-002 Parameter H_TOTAL 800 / H_SYNC 96 / H_DISP_START 144 / H_DISP_END 783: horizontal timing, in pixels.
REQ-003 Parameter V_TOTAL 525 / V_SYNC 2 / V_DISP_START 35 / V_DISP_END 514: vertical timing, in lines.
REQ-004 clk, input, 1: master clock; all logic is clocked on its rising edge.
REQ-005 rst, input, 1: synchronous, active-low reset.
REQ-006 rgb_in, input, 12: pixel colour from the drawing logic, 4:4:4 RGB, corresponding to the current hCount/vCount.
REQ-007 hCount, output, 10: horizontal pixel counter, 0..H_TOTAL-1.
REQ-008 vCount, output, 10: vertical line counter, 0..V_TOTAL-1.
REQ-009 bright, output, 1: high while hCount/vCount lie in the display area.
REQ-010 pix_en, output, 1: one-clk strobe, once per pixel period.
REQ-011 frame_tick, output, 1: one-clk strobe at the end of each frame; used as the slow motion clock enable.
REQ-012 hSync, output, 1: registered horizontal sync, active low.
REQ-013 vSync, output, 1: registered vertical sync, active low.
REQ-014 rgb_out, output, 12: registered, blanked colour to the DAC pins.

Function
REQ-015 div_cnt SHALL count 0..CLK_DIV-1 on every clk and wrap to 0.
REQ-016 pix_en SHALL be combinational and high exactly when div_cnt==CLK_DIV-1.
REQ-017 On a clk edge with pix_en=1, hCount SHALL increment, or wrap 799->0.
REQ-018 On that same wrap edge, vCount SHALL increment, or wrap 524->0; vCount SHALL NOT change on any other edge.
REQ-019 hCount and vCount SHALL hold their values on edges with pix_en=0.
REQ-020 bright SHALL be combinational: 144<=hCount<=783 AND 35<=vCount<=514, giving exactly 640x480 bright pixels per frame.
REQ-021 Internal sync terms: hs_c = (hCount >= H_SYNC); vs_c = (vCount >= V_SYNC).
REQ-022 Output stage, on a pix_en edge, using the pre-increment counter values:
- hSync <= hs_c
- vSync <= vs_c
- rgb_out <= bright ? rgb_in : 12'h000
REQ-023 hSync, vSync and rgb_out SHALL therefore lag hCount/vCount by exactly one pixel period, and SHALL hold between pix_en edges.
REQ-024 frame_tick SHALL be high for exactly one clk: the cycle in which pix_en=1, hCount==799 and vCount==524.
REQ-025 The frame_tick period SHALL be 800*525*CLK_DIV clks, i.e. 1,680,000 clks at the default CLK_DIV.
REQ-026 rgb_in SHALL be sampled only on pix_en edges; changes on other cycles SHALL have no effect.
REQ-027 Out of bright, rgb_out SHALL be 0 regardless of rgb_in, including during porches and sync pulses.
REQ-028 All counter arithmetic SHALL be unsigned 10-bit; hCount and vCount SHALL never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-029 While rst=0 at a clk edge, the block SHALL load:
- div_cnt=0, hCount=0, vCount=0
- hSync=1, vSync=1
- rgb_out=0
REQ-030 Consequently frame_tick=0 and pix_en=0 during reset.
REQ-031 Reset SHALL take priority over pix_en on the same edge.
REQ-032 Reset asserted mid-frame SHALL abort the frame.
REQ-033 After any reset, the first pix_en SHALL occur CLK_DIV-1 clks after rst rises, and timing SHALL restart from (0,0).
REQ-034 No output SHALL glitch to X after reset; registered outputs SHALL be defined from the first reset edge.

Verification
REQ-035 Release rst, then count clks -> pix_en high on clk 3, 7, 11, ...; hCount steps 0->1->2 on those edges.
REQ-036 Run to hCount=799, vCount=10 -> on the next pix_en, hCount=0 and vCount=11.
REQ-036 (cont.) On the first pix_en edge after that wrap, hSync goes low and stays low for 96 pixel periods.
REQ-037 Drive rgb_in=12'hF00 constantly -> rgb_out=12'hF00 only in the pixel after (144..783, 35..514), and 12'h000 elsewhere.
REQ-037 (cont.) The same run SHALL show exactly 307,200 pixel periods with a non-zero rgb_out per frame.
REQ-038 Run two full frames -> frame_tick pulses are exactly 1,680,000 clks apart and each is 1 clk wide.
REQ-038 (cont.) vSync is low for exactly 2*800 pixel periods per frame.
REQ-039 Assert rst=0 for 1 clk at hCount=400, vCount=300, with rgb_in=12'h0F0 -> next edge shows:
- hCount=0, vCount=0
- rgb_out=0, hSync=vSync=1
REQ-039 (cont.) After release, pix_en returns 3 clks later.
REQ-040 Toggle rgb_in every clk while inside the display area -> rgb_out changes only on pix_en edges, each time carrying the value present on that edge.
